// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter
//  Purpose  : N-digit BCD up/down counter over [MIN_VAL..MAX_VAL] with
//             wrap or saturate at the bounds, range-checked parallel load,
//             clear, and zero-latency carry/borrow for chaining time fields.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 99,
  parameter int MIN_VAL = 0,
  parameter bit WRAP    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_bcd,
  input  logic                  i_up,
  input  logic                  i_down,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_carryup,
  output logic                  o_borrowdown,
  output logic                  o_at_max,
  output logic                  o_at_min,
  output logic                  o_load_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time helpers
  // --------------------------------------------------------------------------
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal integer to packed BCD, digit 0 in the low nibble.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // +1 with per-digit ripple: a 9 rolls to 0 and carries into the next digit.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // -1 with per-digit borrow: a 0 rolls to 9 and borrows from the next digit.
  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // True when every nibble holds a legal decimal digit.
  function automatic logic digits_ok(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (DIGITS < 1) begin : g_err_digits
      $error("bcd_mod_counter: DIGITS must be >= 1");
    end
    if (longint'(MAX_VAL) >= pow10(DIGITS)) begin : g_err_max
      $error("bcd_mod_counter: MAX_VAL does not fit in DIGITS digits");
    end
    if (MIN_VAL > MAX_VAL) begin : g_err_min
      $error("bcd_mod_counter: MIN_VAL exceeds MAX_VAL");
    end
  endgenerate

  localparam logic [4*DIGITS-1:0] c_max_bcd = to_bcd(MAX_VAL);
  localparam logic [4*DIGITS-1:0] c_min_bcd = to_bcd(MIN_VAL);

  // --------------------------------------------------------------------------
  // State and combinational decode
  // --------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                load_err_q, load_err_d;

  logic                w_step_up;
  logic                w_step_dn;
  logic                w_load_ok;
  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;

  assign w_step_up = i_up & ~i_down;
  assign w_step_dn = i_down & ~i_up;
  assign w_inc     = bcd_inc(count_q);
  assign w_dec     = bcd_dec(count_q);

  // With all nibbles legal, BCD ordering equals unsigned vector ordering,
  // so the range test can compare the packed vectors directly.
  assign w_load_ok = digits_ok(i_load_bcd)
                   & (i_load_bcd >= c_min_bcd)
                   & (i_load_bcd <= c_max_bcd);

  assign o_at_max = (count_q == c_max_bcd);
  assign o_at_min = (count_q == c_min_bcd);

  assign o_carryup    = WRAP & i_rstn & w_step_up & o_at_max & ~i_clear & ~i_load;
  assign o_borrowdown = WRAP & i_rstn & w_step_dn & o_at_min & ~i_clear & ~i_load;

  assign o_bcd      = count_q;
  assign o_load_err = load_err_q;

  // Next count and load-error pulse, in priority clear > load > step > hold.
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (i_clear) begin
      count_d = c_min_bcd;
    end else if (i_load) begin
      if (w_load_ok) begin
        count_d = i_load_bcd;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (w_step_up) begin
      if (o_at_max) begin
        count_d = WRAP ? c_min_bcd : count_q;
      end else begin
        count_d = w_inc;
      end
    end else if (w_step_dn) begin
      if (o_at_min) begin
        count_d = WRAP ? c_max_bcd : count_q;
      end else begin
        count_d = w_dec;
      end
    end
  end

  // State register with synchronous active-low reset to the lower bound.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count_q    <= c_min_bcd;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_mod_counter
//  Purpose  : Three counter configurations (0..59 wrap, 1..12 wrap,
//             0..23 saturate) checked each cycle against a decimal model,
//             with directed scenarios and hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_mod_counter;

  localparam int MAXV [3] = '{59, 12, 23};
  localparam int MINV [3] = '{0, 1, 0};
  localparam bit WRV  [3] = '{1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rstn [3];
  logic       clr  [3];
  logic       ld   [3];
  logic [7:0] ldv  [3];
  logic       up   [3];
  logic       dn   [3];
  logic [7:0] bcd  [3];
  logic       cu   [3];
  logic       bd   [3];
  logic       amax [3];
  logic       amin [3];
  logic       lerr [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(59), .MIN_VAL(0), .WRAP(1'b1)) u0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_clear(clr[0]), .i_load(ld[0]),
    .i_load_bcd(ldv[0]), .i_up(up[0]), .i_down(dn[0]), .o_bcd(bcd[0]),
    .o_carryup(cu[0]), .o_borrowdown(bd[0]), .o_at_max(amax[0]),
    .o_at_min(amin[0]), .o_load_err(lerr[0]));

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(12), .MIN_VAL(1), .WRAP(1'b1)) u1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_clear(clr[1]), .i_load(ld[1]),
    .i_load_bcd(ldv[1]), .i_up(up[1]), .i_down(dn[1]), .o_bcd(bcd[1]),
    .o_carryup(cu[1]), .o_borrowdown(bd[1]), .o_at_max(amax[1]),
    .o_at_min(amin[1]), .o_load_err(lerr[1]));

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(23), .MIN_VAL(0), .WRAP(1'b0)) u2 (
    .i_clk(clk), .i_rstn(rstn[2]), .i_clear(clr[2]), .i_load(ld[2]),
    .i_load_bcd(ldv[2]), .i_up(up[2]), .i_down(dn[2]), .o_bcd(bcd[2]),
    .o_carryup(cu[2]), .o_borrowdown(bd[2]), .o_at_max(amax[2]),
    .o_at_min(amin[2]), .o_load_err(lerr[2]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // ---------------- decimal reference model ----------------
  int mval   [3];
  bit mknown [3] = '{1'b0, 1'b0, 1'b0};
  bit merr   [3] = '{1'b0, 1'b0, 1'b0};

  // Outputs are checked at the falling edge; the inputs seen there are the
  // ones the next rising edge will sample, so the model advances here too.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit ecarry, eborrow;
      int lv;
      if (mknown[k]) begin
        check($sformatf("u%0d bcd", k), bcd[k], to_bcd(mval[k]));
        check($sformatf("u%0d at_max", k), amax[k], mval[k] == MAXV[k]);
        check($sformatf("u%0d at_min", k), amin[k], mval[k] == MINV[k]);
        check($sformatf("u%0d load_err", k), lerr[k], merr[k]);
      end
      if (mknown[k] || !rstn[k]) begin
        ecarry  = WRV[k] && rstn[k] && up[k] && !dn[k] && !clr[k] && !ld[k]
                  && mknown[k] && (mval[k] == MAXV[k]);
        eborrow = WRV[k] && rstn[k] && dn[k] && !up[k] && !clr[k] && !ld[k]
                  && mknown[k] && (mval[k] == MINV[k]);
        check($sformatf("u%0d carryup", k), cu[k], ecarry);
        check($sformatf("u%0d borrowdown", k), bd[k], eborrow);
      end
      if (!rstn[k]) begin
        mval[k]   = MINV[k];
        merr[k]   = 1'b0;
        mknown[k] = 1'b1;
      end else if (mknown[k]) begin
        merr[k] = 1'b0;
        if (clr[k]) begin
          mval[k] = MINV[k];
        end else if (ld[k]) begin
          lv = int'(ldv[k][7:4]) * 10 + int'(ldv[k][3:0]);
          if (ldv[k][7:4] <= 4'd9 && ldv[k][3:0] <= 4'd9 && lv >= MINV[k] && lv <= MAXV[k])
            mval[k] = lv;
          else
            merr[k] = 1'b1;
        end else if (up[k] && !dn[k]) begin
          if (mval[k] == MAXV[k]) mval[k] = WRV[k] ? MINV[k] : mval[k];
          else                    mval[k] = mval[k] + 1;
        end else if (dn[k] && !up[k]) begin
          if (mval[k] == MINV[k]) mval[k] = WRV[k] ? MAXV[k] : mval[k];
          else                    mval[k] = mval[k] - 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b1; clr[k] = 1'b0; ld[k] = 1'b0;
      ldv[k] = 8'h00; up[k] = 1'b0; dn[k] = 1'b0;
    end
  endtask

  // Present inputs to one unit and stop at the falling edge, where the
  // combinational carry/borrow can be inspected before the step commits.
  task automatic apply(input int k, input logic r, input logic c, input logic l,
                       input logic [7:0] v, input logic u, input logic d);
    rstn[k] = r; clr[k] = c; ld[k] = l; ldv[k] = v; up[k] = u; dn[k] = d;
    @(negedge clk);
    #1;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic step(input int k, input logic c, input logic l,
                      input logic [7:0] v, input logic u, input logic d);
    apply(k, 1'b1, c, l, v, u, d);
    fin();
  endtask

  initial begin
    idle_all();
    for (int k = 0; k < 3; k++) rstn[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset u0", bcd[0], 8'h00);
    check("reset u1", bcd[1], 8'h01);
    check("reset u2", bcd[2], 8'h00);
    check("reset err u0", lerr[0], 1'b0);
    idle_all();

    // 0..59 wrap: load, count across MAX with carry only at 0x59
    step(0, 0, 1, 8'h58, 0, 0);
    check("t1 load 58", bcd[0], 8'h58);
    apply(0, 1, 0, 0, 8'h00, 1, 0);
    check("t1 carry at 58", cu[0], 1'b0);
    fin();
    check("t1 to 59", bcd[0], 8'h59);
    apply(0, 1, 0, 0, 8'h00, 1, 0);
    check("t1 carry at 59", cu[0], 1'b1);
    fin();
    check("t1 wrap 00", bcd[0], 8'h00);

    // borrow at MIN, then a plain down step
    apply(0, 1, 0, 0, 8'h00, 0, 1);
    check("t2 borrow at 00", bd[0], 1'b1);
    fin();
    check("t2 wrap 59", bcd[0], 8'h59);
    apply(0, 1, 0, 0, 8'h00, 0, 1);
    check("t2 borrow at 59", bd[0], 1'b0);
    fin();
    check("t2 to 58", bcd[0], 8'h58);

    // rejected loads hold the count and pulse the error for one cycle
    step(0, 0, 1, 8'h7A, 0, 0);
    check("t4 bad digit hold", bcd[0], 8'h58);
    check("t4 bad digit err", lerr[0], 1'b1);
    step(0, 0, 0, 8'h00, 0, 0);
    check("t4 err cleared", lerr[0], 1'b0);
    step(0, 0, 1, 8'h60, 0, 0);
    check("t4 range hold", bcd[0], 8'h58);
    check("t4 range err", lerr[0], 1'b1);
    step(0, 0, 1, 8'h37, 0, 0);
    check("t4 load 37", bcd[0], 8'h37);
    check("t4 good no err", lerr[0], 1'b0);

    // decade borrow 40 -> 39
    step(0, 0, 1, 8'h40, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1);
    check("decade borrow 39", bcd[0], 8'h39);

    // 1..12 wrap
    repeat (11) step(1, 0, 0, 8'h00, 1, 0);
    check("t3 reach 12", bcd[1], 8'h12);
    check("t3 at_max", amax[1], 1'b1);
    apply(1, 1, 0, 0, 8'h00, 1, 0);
    check("t3 carry at 12", cu[1], 1'b1);
    fin();
    check("t3 wrap 01", bcd[1], 8'h01);
    apply(1, 1, 0, 0, 8'h00, 0, 1);
    check("t3 borrow at 01", bd[1], 1'b1);
    fin();
    check("t3 wrap 12", bcd[1], 8'h12);
    step(1, 0, 1, 8'h00, 0, 0);
    check("t3 below min hold", bcd[1], 8'h12);
    check("t3 below min err", lerr[1], 1'b1);

    // 0..23 saturate
    step(2, 0, 1, 8'h23, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(2, 1, 0, 0, 8'h00, 1, 0);
      check("t5 no carry sat", cu[2], 1'b0);
      fin();
      check("t5 hold 23", bcd[2], 8'h23);
    end
    step(2, 0, 1, 8'h10, 0, 0);
    step(2, 0, 0, 8'h00, 1, 1);
    check("t5 up+down hold", bcd[2], 8'h10);
    step(2, 0, 0, 8'h00, 0, 1);
    check("t5 down 09", bcd[2], 8'h09);

    // reset and clear precedence
    step(0, 0, 1, 8'h45, 0, 0);
    check("t6 load 45", bcd[0], 8'h45);
    apply(0, 0, 0, 0, 8'h00, 1, 0);
    check("t6 no carry in reset", cu[0], 1'b0);
    fin();
    check("t6 reset to min", bcd[0], 8'h00);
    check("t6 reset err", lerr[0], 1'b0);
    step(0, 0, 1, 8'h45, 0, 0);
    apply(0, 0, 1, 1, 8'h7A, 1, 0);
    fin();
    check("t6 reset+clr+ld", bcd[0], 8'h00);
    check("t6 reset+clr+ld err", lerr[0], 1'b0);
    step(0, 0, 1, 8'h45, 0, 0);
    step(0, 1, 1, 8'h7A, 0, 0);
    check("t6 clear wins", bcd[0], 8'h00);
    check("t6 clear no err", lerr[0], 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
